// File: rtl/secuenciador_pkg.sv
// Shared types and constants for the chunked add/subtract sequencer.
// The overflow helper is only referenced when SECUENCIADOR_OVERFLOW_EN is defined.
package secuenciador_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } seq_state_t;

  localparam int CHUNK_W   = 16;
  localparam int CHUNK_LOG = $clog2(CHUNK_W);

  // Signed overflow: carry into the MSB (recovered from the MSB sum bit) XOR carry out.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                      input logic s_msb, input logic c_out);
    return (a_msb ^ b_msb ^ s_msb) ^ c_out;
  endfunction

endpackage

// File: rtl/sumador_16_bits.sv
// Combinational 16-bit chunk adder with carry in and carry out.
module sumador_16_bits (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] s,
  output logic        cout
);

  logic [16:0] full_s;

  assign full_s = {1'b0, a} + {1'b0, b} + {16'b0, cin};
  assign s      = full_s[15:0];
  assign cout   = full_s[16];

endmodule

// File: rtl/secuenciador_suma_64.sv
// WIDTH-bit add/subtract that reuses one 16-bit adder across WIDTH/16 cycles, LSB chunk first.
// Optional macro SECUENCIADOR_OVERFLOW_EN adds the registered signed-overflow output ovf.
module secuenciador_suma_64
  import secuenciador_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef SECUENCIADOR_OVERFLOW_EN
  output logic             ovf,
`endif
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int N       = WIDTH / CHUNK_W;
  localparam int IDX_W   = (N > 1) ? $clog2(N) : 1;
  localparam int SHIFT_W = IDX_W + CHUNK_LOG;

  generate
    if ((WIDTH % CHUNK_W) != 0 || WIDTH < CHUNK_W) begin : g_width_check
      $error("secuenciador_suma_64: WIDTH must be a non-zero multiple of 16");
    end
  endgenerate

  seq_state_t       state_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             carry_r;
  logic [IDX_W-1:0] idx_r;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             in_ready_r;
  logic             out_valid_r;

  logic [SHIFT_W-1:0] shift_s;
  logic [WIDTH-1:0]   a_shifted_s;
  logic [WIDTH-1:0]   b_shifted_s;
  logic [CHUNK_W-1:0] a_chunk_s;
  logic [CHUNK_W-1:0] b_chunk_s;
  logic [CHUNK_W-1:0] chunk_sum_s;
  logic               chunk_cout_s;
  logic               last_chunk_s;

  // Chunk mux: select chunk[idx] of both captured operands.
  always_comb begin
    shift_s      = {idx_r, {CHUNK_LOG{1'b0}}};
    a_shifted_s  = a_r >> shift_s;
    b_shifted_s  = b_r >> shift_s;
    a_chunk_s    = a_shifted_s[CHUNK_W-1:0];
    b_chunk_s    = b_shifted_s[CHUNK_W-1:0];
    last_chunk_s = (idx_r == IDX_W'(N - 1));
  end

  sumador_16_bits u_sumador (
    .a    (a_chunk_s),
    .b    (b_chunk_s),
    .cin  (carry_r),
    .s    (chunk_sum_s),
    .cout (chunk_cout_s)
  );

`ifdef SECUENCIADOR_OVERFLOW_EN
  logic ovf_r;

  // Overflow flag, captured together with cout on the last chunk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_r <= 1'b0;
    end else if (state_r == RUN && last_chunk_s) begin
      ovf_r <= signed_ovf(a_r[WIDTH-1], b_r[WIDTH-1], chunk_sum_s[CHUNK_W-1], chunk_cout_s);
    end else begin
      ovf_r <= ovf_r;
    end
  end

  assign ovf = ovf_r;
`endif

  // Sequencer FSM with operand capture, chunk result writes and registered handshakes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      a_r         <= '0;
      b_r         <= '0;
      carry_r     <= 1'b0;
      idx_r       <= '0;
      sum_r       <= '0;
      cout_r      <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid && in_ready_r) begin
            a_r        <= a;
            b_r        <= b ^ {WIDTH{sub}};
            carry_r    <= sub ? 1'b1 : cin;
            idx_r      <= '0;
            in_ready_r <= 1'b0;
            state_r    <= RUN;
          end
        end
        RUN: begin
          for (int i = 0; i < N; i++) begin
            if (idx_r == IDX_W'(i)) begin
              sum_r[i*CHUNK_W +: CHUNK_W] <= chunk_sum_s;
            end
          end
          carry_r <= chunk_cout_s;
          if (last_chunk_s) begin
            idx_r       <= '0;
            cout_r      <= chunk_cout_s;
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end else begin
            idx_r <= idx_r + IDX_W'(1'b1);
          end
        end
        DONE: begin
          // Result is held untouched until the consumer takes it.
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end
        end
        default: begin
          idx_r       <= '0;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign sum       = sum_r;
  assign cout      = cout_r;

endmodule

// File: tb/tb_secuenciador_suma_64.sv
// Directed and randomized checks of secuenciador_suma_64 against a plain-arithmetic reference.
// Define SECUENCIADOR_OVERFLOW_EN to also check the ovf output.
module tb_secuenciador_suma_64;

  localparam int W   = 64;
  localparam int LAT = W / 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SECUENCIADOR_OVERFLOW_EN
  logic         ovf;
`endif

  int errors = 0;
  int checks = 0;

  logic [W-1:0] last_sum;
  logic         last_cout;
  logic         last_ovf;

  always #5 clk = ~clk;

  secuenciador_suma_64 #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef SECUENCIADOR_OVERFLOW_EN
    .ovf       (ovf),
`endif
    .sum       (sum),
    .cout      (cout)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: unsigned modular result, carry/no-borrow, and signed range overflow.
  function automatic logic [W+1:0] ref_model(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                             input logic rcin, input logic rsub);
    logic [W:0]          full;
    logic [W-1:0]        s;
    logic                co;
    logic                ov;
    logic signed [W+1:0] sa;
    logic signed [W+1:0] sb;
    logic signed [W+1:0] sres;
    logic signed [W+1:0] max_pos;
    logic signed [W+1:0] min_neg;
    sa      = $signed({ra[W-1], ra[W-1], ra});
    sb      = $signed({rb[W-1], rb[W-1], rb});
    max_pos = $signed({3'b000, {(W-1){1'b1}}});
    min_neg = $signed({3'b111, {(W-1){1'b0}}});
    if (rsub) begin
      s    = ra - rb;
      co   = (ra >= rb);
      sres = sa - sb;
    end else begin
      full = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rcin};
      s    = full[W-1:0];
      co   = full[W];
      sres = sa + sb + $signed({{(W+1){1'b0}}, rcin});
    end
    ov = (sres > max_pos) || (sres < min_neg);
    return {ov, co, s};
  endfunction

  task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic ocin,
                        input logic osub, input int stall);
    int           waitc;
    int           lat;
    logic [W+1:0] exp;
    waitc = 0;
    while (!in_ready && waitc < 50) begin
      @(posedge clk); #1;
      waitc++;
    end
    check("in_ready_idle", {63'b0, in_ready}, 64'd1);
    a = oa; b = ob; cin = ocin; sub = osub; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = {$urandom, $urandom}; b = {$urandom, $urandom};
    cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
    exp = ref_model(oa, ob, ocin, osub);
    lat = 0;
    while (!out_valid && lat < 20) begin
      check("in_ready_busy", {63'b0, in_ready}, 64'd0);
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 64'(lat), 64'(LAT));
    check("sum", sum, exp[W-1:0]);
    check("cout", {63'b0, cout}, {63'b0, exp[W]});
`ifdef SECUENCIADOR_OVERFLOW_EN
    check("ovf", {63'b0, ovf}, {63'b0, exp[W+1]});
    last_ovf = ovf;
`endif
    last_sum  = sum;
    last_cout = cout;
    for (int k = 0; k < stall; k++) begin
      @(posedge clk); #1;
      check("hold_valid", {63'b0, out_valid}, 64'd1);
      check("hold_sum", sum, exp[W-1:0]);
      check("hold_cout", {63'b0, cout}, {63'b0, exp[W]});
      check("hold_in_ready", {63'b0, in_ready}, 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("valid_drop", {63'b0, out_valid}, 64'd0);
    check("ready_back", {63'b0, in_ready}, 64'd1);
  endtask

  initial begin
    int stall;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", {63'b0, in_ready}, 64'd1);
    check("rst_out_valid", {63'b0, out_valid}, 64'd0);
    check("rst_sum", sum, 64'd0);
    check("rst_cout", {63'b0, cout}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: full carry ripple
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 0);
    check("t1_sum", last_sum, 64'h0);
    check("t1_cout", {63'b0, last_cout}, 64'd1);

    // 2: carry across the first chunk boundary
    run_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, 0);
    check("t2_sum", last_sum, 64'h0000_0000_0001_0000);
    check("t2_cout", {63'b0, last_cout}, 64'd0);

    // 3: subtraction with and without borrow (cin ignored)
    run_op(64'h5, 64'h7, 1'b1, 1'b1, 0);
    check("t3a_sum", last_sum, 64'hFFFF_FFFF_FFFF_FFFE);
    check("t3a_cout", {63'b0, last_cout}, 64'd0);
    run_op(64'h7, 64'h5, 1'b0, 1'b1, 0);
    check("t3b_sum", last_sum, 64'h2);
    check("t3b_cout", {63'b0, last_cout}, 64'd1);

    // 4: backpressure for 10 cycles
    run_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b0, 10);
    check("t4_sum", last_sum, 64'h2222_2222_2222_2212);

    // 5: async reset in the 2nd RUN cycle, then a fresh op
    a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'hFFFF_FFFF_FFFF_FFFF; cin = 1'b1; sub = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("t5_in_ready", {63'b0, in_ready}, 64'd1);
    check("t5_out_valid", {63'b0, out_valid}, 64'd0);
    check("t5_sum", sum, 64'd0);
    check("t5_cout", {63'b0, cout}, 64'd0);
`ifdef SECUENCIADOR_OVERFLOW_EN
    check("t5_ovf", {63'b0, ovf}, 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(64'd3, 64'd4, 1'b0, 1'b0, 0);
    check("t5_next_sum", last_sum, 64'd7);

`ifdef SECUENCIADOR_OVERFLOW_EN
    // 6: signed overflow cases
    run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 0);
    check("t6a_ovf", {63'b0, last_ovf}, 64'd1);
    check("t6a_cout", {63'b0, last_cout}, 64'd0);
    run_op(64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1, 0);
    check("t6b_ovf", {63'b0, last_ovf}, 64'd1);
    run_op(64'h1, 64'h1, 1'b0, 1'b0, 0);
    check("t6c_ovf", {63'b0, last_ovf}, 64'd0);
`endif

    // Random regression with producer idle gaps and consumer stalls
    for (int n = 0; n < 40; n++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0: ra = 64'hFFFF_FFFF_FFFF_FFFF;
        1: rb = 64'hFFFF_FFFF_FFFF_FFFF;
        2: rb = ra;
        3: ra = {1'b0, {63{1'b1}}};
        default: ra = ra;
      endcase
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
      stall = $urandom_range(0, 3);
      run_op(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), stall);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
